mem_port_arbiter: RTL and testbench

Arbitrates the single unified instruction/data memory port of the multicycle RISC-V core between two requesters: the core (port C, fetch and LW/SW traffic) and the program loader (port L, memory image download and readback). It holds each requester off with a request/acknowledge handshake, issues exactly one memory access per grant, and absorbs a fixed memory read latency. It sits between the core's memory address/data mux and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports (core C, loader L) and the memory macro
//   port of mem_port_arbiter.
//   slave  : arbiter view (samples requests and mem_rdata, drives acks,
//            read data, memory strobes and status)
//   master : environment view (requesters and memory model)
//
//   Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable and
//   holds it until its one-cycle *_ack pulse. A req still high in the cycle
//   after the ack is taken as a new access.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  c_req;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_ack;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_ack;
  logic [DATA_WIDTH-1:0] l_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  grant_id;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output c_ack, c_rdata, l_ack, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_id
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  c_ack, c_rdata, l_ack, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port of the multicycle RISC-V core
//   between the core (port C) and the program loader (port L). One memory
//   access is issued per grant; reads absorb a fixed MEM_LATENCY.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : mem_port_arbiter_if.slave (requesters + memory macro)
//   dbg_state_o  : current FSM state (IDLE=0, ISSUE=1, WAIT=2, ACK=3)
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH : bus widths
//   MEM_LATENCY            : read latency in cycles, legal range 1..4
//
// Build option
//   LOADER_PRIORITY_EN : when defined the loader always wins a tie (the core
//                        may starve); otherwise ties are round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // Wait counter reload; counting down to 0 gives exactly MEM_LATENCY
  // WAIT cycles.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  logic [1:0]            state_q,      state_d;
  logic                  we_q,         we_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
  logic [1:0]            cnt_q,        cnt_d;
  logic                  grant_q,      grant_d;
  logic                  last_grant_q, last_grant_d;

  logic                  pick_l;

  // Winner select, only meaningful in IDLE with at least one req high.
`ifdef LOADER_PRIORITY_EN
  assign pick_l = bus.l_req;
`else
  // On a tie the requester that did not win last time goes next.
  assign pick_l = bus.l_req & (~bus.c_req | ~last_grant_q);
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (bus.c_req || bus.l_req) begin
          grant_d = pick_l;
          we_d    = pick_l ? bus.l_we    : bus.c_we;
          addr_d  = pick_l ? bus.l_addr  : bus.c_addr;
          wdata_d = pick_l ? bus.l_wdata : bus.c_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_ACK: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= 2'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Strobes, acks and status decode from registered state only, so an
  // asynchronous reset clears them at once and no input reaches them
  // combinationally.
  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.c_ack     = (state_q == S_ACK) & ~grant_q;
  assign bus.l_ack     = (state_q == S_ACK) &  grant_q;
  assign bus.c_rdata   = rdata_q;
  assign bus.l_rdata   = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant_id  = grant_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. dut1 uses MEM_LATENCY=1 with a scripted
//   memory model and two requester drivers; dut3 uses MEM_LATENCY=3 and is
//   driven directly. Build with +define+LOADER_PRIORITY_EN on both files to
//   check the loader-priority grant order.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();
  logic [1:0] dbg1, dbg3;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .dbg_state_o(dbg1)
  );
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .dbg_state_o(dbg3)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents as a fixed function of address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // One-cycle read latency: data valid in the WAIT cycle only.
  always @(posedge clk) begin
    if (if1.mem_en && !if1.mem_we) if1.mem_rdata <= mem_model(if1.mem_addr);
    else                           if1.mem_rdata <= 32'hBAD0_0BAD;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {grant id, expected rdata at ack}
  logic [64:0] iss_q[$];   // {we, addr, wdata} expected at each issue
  logic [64:0] c_pend[$];  // pending core transactions {we, addr, wdata}
  logic [64:0] l_pend[$];
  logic [31:0] last_rd = 32'h0;
  logic        prev_ack = 1'b0;

  task automatic queue_req(input bit id, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (id) l_pend.push_back({we, addr, wdata});
    else    c_pend.push_back({we, addr, wdata});
  endtask

  // Called in expected grant order.
  task automatic expect_txn(input bit id, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    if (!we) last_rd = mem_model(addr);
    iss_q.push_back({we, addr, wdata});
    exp_q.push_back({id, last_rd});
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    logic [64:0] s;
    if (!rst) begin
      if (if1.c_ack || if1.l_ack) begin
        check_eq("ack_onehot", 72'(if1.c_ack & if1.l_ack), 72'd0);
        check_eq("ack_single_cycle", 72'(prev_ack), 72'd0);
        if (exp_q.size() == 0) begin
          check_eq("ack_unexpected", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("ack_id", 72'(if1.l_ack), 72'(e[32]));
          check_eq("grant_id", 72'(if1.grant_id), 72'(e[32]));
          check_eq("ack_rdata", 72'(if1.l_ack ? if1.l_rdata : if1.c_rdata), 72'(e[31:0]));
        end
      end
      prev_ack = if1.c_ack | if1.l_ack;
      if (if1.mem_en) begin
        if (iss_q.size() == 0) begin
          check_eq("issue_unexpected", 72'd1, 72'd0);
        end else begin
          s = iss_q.pop_front();
          check_eq("issue_fields", 72'({if1.mem_we, if1.mem_addr, if1.mem_wdata}), 72'(s));
        end
      end
    end else begin
      prev_ack = 1'b0;
    end
  end

  // ---------------- requester drivers (dut1) ----------------
  // A requester keeps req high across its ack when more work is pending,
  // which presents back-to-back ties to the arbiter.
  initial begin
    bit act;
    act = 1'b0;
    if1.c_req = 1'b0; if1.c_we = 1'b0; if1.c_addr = '0; if1.c_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if1.c_req = 1'b0;
        act = 1'b0;
      end else begin
        if (act && if1.c_ack) begin
          void'(c_pend.pop_front());
          act = 1'b0;
        end
        if (!act && c_pend.size() > 0) begin
          {if1.c_we, if1.c_addr, if1.c_wdata} = c_pend[0];
          if1.c_req = 1'b1;
          act = 1'b1;
        end else if (!act) begin
          if1.c_req = 1'b0;
        end
      end
    end
  end

  initial begin
    bit act;
    act = 1'b0;
    if1.l_req = 1'b0; if1.l_we = 1'b0; if1.l_addr = '0; if1.l_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if1.l_req = 1'b0;
        act = 1'b0;
      end else begin
        if (act && if1.l_ack) begin
          void'(l_pend.pop_front());
          act = 1'b0;
        end
        if (!act && l_pend.size() > 0) begin
          {if1.l_we, if1.l_addr, if1.l_wdata} = l_pend[0];
          if1.l_req = 1'b1;
          act = 1'b1;
        end else if (!act) begin
          if1.l_req = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_outstanding", 72'(exp_q.size()), 72'd0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if3.c_req = 1'b0; if3.c_we = 1'b0; if3.c_addr = '0; if3.c_wdata = '0;
    if3.l_req = 1'b0; if3.l_we = 1'b0; if3.l_addr = '0; if3.l_wdata = '0;
    if3.mem_rdata = 32'hBAD0_0BAD;

    // Reset state
    #12;
    check_eq("rst_outputs", 72'({if1.c_ack, if1.l_ack, if1.mem_en, if1.mem_we, if1.busy, if1.grant_id}), 72'd0);
    check_eq("rst_addr_data", 72'({if1.mem_addr, if1.c_rdata}), 72'd0);
    check_eq("rst_state", 72'(dbg1), 72'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Core read, latency 1, address 0x10
    queue_req(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    expect_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);                                   // t
    @(negedge clk);                                   // t+1
    check_eq("rd_issue_en", 72'({if1.mem_en, if1.mem_we, if1.busy}), 72'b101);
    check_eq("rd_issue_addr", 72'(if1.mem_addr), 72'h10);
    @(negedge clk);                                   // t+2
    check_eq("rd_wait_en", 72'({if1.mem_en, if1.c_ack}), 72'd0);
    @(negedge clk);                                   // t+3
    check_eq("rd_ack", 72'({if1.c_ack, if1.l_ack}), 72'b10);
    check_eq("rd_data", 72'(if1.c_rdata), 72'hDEAD_BEEF);
    wait_drain(20);

    // Loader write 0x40 <- 0x12345678
    @(posedge clk); #1;
    queue_req(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    expect_txn(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    @(negedge clk);                                   // t
    @(negedge clk);                                   // t+1
    check_eq("wr_issue", 72'({if1.mem_en, if1.mem_we, if1.grant_id}), 72'b111);
    check_eq("wr_issue_fields", 72'({if1.mem_addr, if1.mem_wdata}), 72'h0000_0040_1234_5678);
    @(negedge clk);                                   // t+2
    check_eq("wr_ack", 72'({if1.l_ack, if1.c_ack}), 72'b10);
    check_eq("wr_rdata_kept", 72'(if1.l_rdata), 72'hDEAD_BEEF);
    @(negedge clk);
    check_eq("wr_after_ack", 72'({if1.l_ack, if1.busy}), 72'd0);
    wait_drain(20);

    // Simultaneous requests, two per port held back to back
    @(posedge clk); #1;
    queue_req(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    queue_req(1'b0, 1'b1, 32'h0000_0104, 32'h1111_2222);
    queue_req(1'b1, 1'b1, 32'h0000_0200, 32'h3333_4444);
    queue_req(1'b1, 1'b0, 32'h0000_0204, 32'h0);
`ifdef LOADER_PRIORITY_EN
    expect_txn(1'b1, 1'b1, 32'h0000_0200, 32'h3333_4444);
    expect_txn(1'b1, 1'b0, 32'h0000_0204, 32'h0);
    expect_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    expect_txn(1'b0, 1'b1, 32'h0000_0104, 32'h1111_2222);
`else
    expect_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    expect_txn(1'b1, 1'b1, 32'h0000_0200, 32'h3333_4444);
    expect_txn(1'b0, 1'b1, 32'h0000_0104, 32'h1111_2222);
    expect_txn(1'b1, 1'b0, 32'h0000_0204, 32'h0);
`endif
    wait_drain(60);

    // Random single-requester traffic
    for (int i = 0; i < 8; i++) begin
      bit          id, we;
      logic [31:0] a, d;
      id = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255)) << 2;
      d  = $urandom;
      queue_req(id, we, a, d);
      expect_txn(id, we, a, d);
      wait_drain(20);
    end

    // MEM_LATENCY=3 read: data valid only in the third WAIT cycle
    @(posedge clk); #1;                               // t
    if3.c_req = 1'b1; if3.c_we = 1'b0; if3.c_addr = 32'h0000_0020;
    @(negedge clk);
    @(negedge clk);                                   // t+1
    check_eq("l3_issue", 72'({if3.mem_en, if3.mem_we, if3.mem_addr}), 72'({1'b1, 1'b0, 32'h20}));
    repeat (3) @(posedge clk);                        // t+4 starts
    #1 if3.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("l3_no_early_ack", 72'({if3.c_ack, dbg3}), 72'({1'b0, 2'd2}));
    @(posedge clk); #1 if3.mem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);                                   // t+5
    check_eq("l3_ack", 72'({if3.c_ack, if3.l_ack}), 72'b10);
    check_eq("l3_rdata", 72'(if3.c_rdata), 72'hCAFE_F00D);
    if3.c_req = 1'b0;
    @(negedge clk);
    check_eq("l3_idle", 72'({if3.c_ack, if3.busy}), 72'd0);

    // Reset pulsed during WAIT abandons the access
    @(posedge clk); #1;
    queue_req(1'b0, 1'b0, 32'h0000_0300, 32'h0);
    iss_q.push_back({1'b0, 32'h0000_0300, 32'h0});
    begin
      int n;
      n = 0;
      while (dbg1 != 2'd2 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("rst_reached_wait", 72'(dbg1), 72'd2);
    #2 rst = 1'b1;
    c_pend.delete();
    #1;
    check_eq("midrst_outputs", 72'({if1.mem_en, if1.c_ack, if1.l_ack, if1.busy}), 72'd0);
    check_eq("midrst_rdata", 72'(if1.c_rdata), 72'd0);
    check_eq("midrst_state", 72'(dbg1), 72'd0);
    last_rd = 32'h0;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    queue_req(1'b0, 1'b0, 32'h0000_0304, 32'h0);
    expect_txn(1'b0, 1'b0, 32'h0000_0304, 32'h0);
    wait_drain(20);
    check_eq("issues_consumed", 72'(iss_q.size()), 72'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
